// File: rtl/ad7352_rx.sv
// Receiver for the dual AD7352 pair: drives the shared chip select and deserialises
// vcap/icap/vout/iout into a registered sample set with a one-cycle valid strobe.
module ad7352_rx #(
  parameter int unsigned FRAME_CYCLES = 16,
  parameter int unsigned QUIET_CYCLES = 2,
  parameter int unsigned CHECK_LEAD   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        ad_cs,
  input  logic [1:0]  ad_sdata_a,
  input  logic [1:0]  ad_sdata_b,
  output logic [11:0] vcap,
  output logic [11:0] icap,
  output logic [11:0] vout,
  output logic [11:0] iout,
  output logic        sample_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned QuietEff = (QUIET_CYCLES < 1) ? 1 : QUIET_CYCLES;
  localparam int unsigned CntW     = $clog2(FRAME_CYCLES);
  localparam int unsigned QCntW    = (QuietEff > 1) ? $clog2(QuietEff) : 1;

  localparam logic [CntW-1:0]  CntLead  = CntW'(1);
  localparam logic [CntW-1:0]  CntFirst = CntW'(2);
  localparam logic [CntW-1:0]  CntLast  = CntW'(13);
  localparam logic [CntW-1:0]  CntEnd   = CntW'(FRAME_CYCLES - 1);
  localparam logic [QCntW-1:0] QCntEnd  = QCntW'(QuietEff - 1);

  typedef enum logic [1:0] {StIdle, StConv, StQuiet} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [QCntW-1:0] qcnt_q;
  logic             lead_q;
  logic [11:0]      sh_vcap_q, sh_icap_q, sh_vout_q, sh_iout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      qcnt_q       <= '0;
      lead_q       <= 1'b0;
      sh_vcap_q    <= '0;
      sh_icap_q    <= '0;
      sh_vout_q    <= '0;
      sh_iout_q    <= '0;
      ad_cs        <= 1'b1;
      busy         <= 1'b0;
      vcap         <= '0;
      icap         <= '0;
      vout         <= '0;
      iout         <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (enable) begin
            state_q <= StConv;
            ad_cs   <= 1'b0;
            busy    <= 1'b1;
            cnt_q   <= '0;
          end
        end
        StConv: begin
          cnt_q <= cnt_q + 1'b1;
          // Data lines are only sampled inside the capture window, so X outside it is harmless.
          if (cnt_q == CntLead) begin
            lead_q <= |{ad_sdata_a, ad_sdata_b};
          end
          if (cnt_q >= CntFirst && cnt_q <= CntLast) begin
            sh_vcap_q <= {sh_vcap_q[10:0], ad_sdata_b[1]};
            sh_icap_q <= {sh_icap_q[10:0], ad_sdata_b[0]};
            sh_vout_q <= {sh_vout_q[10:0], ad_sdata_a[1]};
            sh_iout_q <= {sh_iout_q[10:0], ad_sdata_a[0]};
          end
          // Outputs load straight from the final bit so they are valid the cycle after cnt=13.
          if (cnt_q == CntLast) begin
            if ((CHECK_LEAD != 0) && lead_q) begin
              frame_err <= 1'b1;
            end else begin
              vcap         <= {sh_vcap_q[10:0], ad_sdata_b[1]};
              icap         <= {sh_icap_q[10:0], ad_sdata_b[0]};
              vout         <= {sh_vout_q[10:0], ad_sdata_a[1]};
              iout         <= {sh_iout_q[10:0], ad_sdata_a[0]};
              sample_valid <= 1'b1;
            end
          end
          if (cnt_q == CntEnd) begin
            state_q <= StQuiet;
            ad_cs   <= 1'b1;
            busy    <= 1'b0;
            qcnt_q  <= '0;
          end
        end
        StQuiet: begin
          if (qcnt_q == QCntEnd) begin
            if (enable) begin
              state_q <= StConv;
              ad_cs   <= 1'b0;
              busy    <= 1'b1;
              cnt_q   <= '0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            qcnt_q <= qcnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          ad_cs   <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ad7352_rx.md
Name: ad7352_rx

Overview:
- FPGA-side receiver for the dual AD7352 A/D pair that samples the launcher power stage: capacitor voltage, capacitor current, output voltage and output (coil) current.
- Drives the shared active-low chip select and deserialises four 12-bit channels from the two 2-bit serial data buses.
- Presents each conversion as a parallel, registered sample set with a one-cycle valid strobe.
- Sits between the blaster top-level pins (ad_cs, ad_sdata_a, ad_sdata_b) and the PWM/current control loop.

Parameters:
- FRAME_CYCLES, 16: clk cycles ad_cs is held low per conversion. Legal range is 14 or more.
- QUIET_CYCLES, 2: minimum clk cycles ad_cs is held high between frames. Values below 1 are treated as 1.
- CHECK_LEAD, 1: when 1, enables the leading-zero check that drives frame_err.

Ports:
- clk  in  1  system clock. The ADC SCLK is this clock inverted; the ADC launches data on the clk negedge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run conversions continuously while high.
- ad_cs  out  1  ADC chip select, active low.
- ad_sdata_a  in  2  [1] vout serial, [0] iout serial.
- ad_sdata_b  in  2  [1] vcap serial, [0] icap serial.
- vcap  out  12  capacitor voltage, LSB = 1/8 V.
- icap  out  12  capacitor current, LSB = 1/256 A.
- vout  out  12  output voltage, LSB = 1/8 V.
- iout  out  12  coil current, LSB = 1/256 A.
- sample_valid  out  1  one-cycle pulse when vcap/icap/vout/iout have been updated.
- frame_err  out  1  one-cycle pulse when a frame is rejected.
- busy  out  1  high while ad_cs is low.

Behaviour:
- Reset (reset low, asynchronous):
  - ad_cs=1; all data outputs 0; sample_valid=0, frame_err=0, busy=0.
  - State IDLE; counters 0; shift registers 0.
  - Takes effect immediately, including mid-frame. ad_cs returns high at once and the partial frame is discarded.
- All outputs are registered. Inputs are captured on the clk posedge.
- States: IDLE, CONV, QUIET.
  - IDLE: ad_cs=1. If enable=1 at a posedge, go to CONV, drive ad_cs=0 and set cnt=0. That posedge is frame cycle 0.
  - CONV: cnt increments each cycle.
    - cnt=1: capture the leading-zero bit on all 4 lines.
    - cnt=2..13: capture data bits 11 down to 0, MSB first. Each line is left-shifted into its own 12-bit register.
    - cnt=FRAME_CYCLES-1: the next state is QUIET and ad_cs goes high.
  - QUIET: hold ad_cs=1 for QUIET_CYCLES cycles. Then:
    - if enable=1, go directly to CONV (frame cycle 0 again);
    - otherwise go to IDLE.
- Result update, at the cycle after cnt=13 (cycle 14 after ad_cs falls):
  - Lead check passed (or CHECK_LEAD=0): load all four outputs together and pulse sample_valid for 1 cycle.
  - Any lead bit nonzero with CHECK_LEAD=1: outputs hold their previous values, frame_err pulses for 1 cycle, sample_valid stays 0.
  - sample_valid and frame_err are never high together.
- Latency: the last data bit is captured at cycle 13; the outputs are valid from cycle 14.
- Throughput: one sample set every FRAME_CYCLES+QUIET_CYCLES cycles (18 at defaults).
- enable is sampled only in IDLE and at the end of QUIET. Dropping enable mid-frame does not abort the frame: the frame completes and delivers its result.
- Data lines are don't-care (may be X) while ad_cs=1. X on the data lines must not propagate into the outputs.
- Outputs are raw unsigned codes. No scaling or saturation is applied; 0xFFF passes through unchanged.
- busy equals ~ad_cs.

Test Plan:
- Single frame: ADC model loaded with vcap=320 V (0xA00), iout=2 A (0x200), icap=0, vout=0; enable pulsed for 1 cycle -> ad_cs low exactly 16 cycles; sample_valid once at cycle 14; vcap=0xA00, iout=0x200, icap=0, vout=0; back to IDLE with ad_cs=1.
- Continuous: enable held high for 100 cycles -> ad_cs falls every 18 cycles, high for exactly 2 cycles between frames; each sample_valid matches the model's latched values from that frame.
- Extremes: all channels 0xFFF, then all 0x000 -> outputs exactly 0xFFF, then 0x000; no frame_err.
- Lead error: force ad_sdata_a[0]=1 at frame cycle 1 -> frame_err pulses at cycle 14; sample_valid stays 0; outputs keep the previous sample.
- Enable drop: deassert enable at cycle 5 of a frame -> frame completes; sample_valid at cycle 14; ad_cs high from cycle 16 and stays high.
- Reset mid-frame: assert reset at cycle 8 -> ad_cs=1 and outputs 0 immediately. After release with enable=1, the first frame starts on the next posedge and yields correct data.
